// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Multi-cycle program-counter controller for the 20-bit datapath.
//   It fetches a 16-bit instruction over a req/ack handshake and then spends
//   one EXEC cycle on it:
//     - BR and BZ are resolved locally.
//     - HALT parks the sequencer.
//     - Every other opcode is handed to the datapath with a one-cycle
//       instr_valid pulse.
//   With zero-wait memory the sequencer completes one instruction every
//   2 cycles.
//
// Parameters
//   RESET_PC  PC loaded at reset and on restart from HALT
//   TIMEOUT   FETCH cycles without imem_ack before entering ERR (1..255)
//
// Optional build macro
//   BRANCH_STATS_EN  adds output taken_cnt, a saturating count of taken
//                    BR/BZ branches. It is cleared by reset and by restart
//                    from HALT.
//
// Ports
//   clk, rst_n   clock; asynchronous active-low reset
//   start        level start request, honoured only in IDLE or HALT
//   imem_req     fetch request, high for the whole FETCH state
//   imem_addr    fetch address (pc while imem_req=1, else 0)
//   imem_ack     memory response, imem_data valid in the same cycle
//   imem_data    instruction: [15:12] opcode, [11:8] unused, [7:0] offset
//   flag_z       datapath zero flag, sampled in EXEC
//   pc           program counter register
//   instr        last fetched instruction
//   instr_valid  one-cycle pulse: instr is a datapath op
//   busy         high in FETCH and EXEC
//   halted       high in HALT
//   err          high in ERR (terminal until reset)
//
// Handshake: imem_req is a level request. A fetch completes on the first
// rising edge where imem_req and imem_ack are both high. If imem_ack and the
// timeout land in the same cycle, the ack wins.
module pc_sequencer #(
   parameter logic [19:0] RESET_PC = 20'h00000,
   parameter int          TIMEOUT  = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        imem_req,
   output logic [19:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_data,
   input  logic        flag_z,
   output logic [19:0] pc,
   output logic [15:0] instr,
   output logic        instr_valid,
   output logic        busy,
   output logic        halted,
   output logic        err
`ifdef BRANCH_STATS_EN
   ,
   output logic [15:0] taken_cnt
`endif
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_EXEC  = 3'd2;
   localparam logic [2:0] S_HALT  = 3'd3;
   localparam logic [2:0] S_ERR   = 3'd4;

   localparam logic [3:0] OP_BR   = 4'hA;
   localparam logic [3:0] OP_BZ   = 4'hB;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

   logic [2:0]  state;
   logic [7:0]  tmo_cnt;
   logic [3:0]  opcode;
   logic [19:0] pc_inc;
   logic [19:0] br_target;
   logic        taken;

   assign opcode    = instr[15:12];
   assign pc_inc    = pc + 20'd1;
   // The sign-extended offset is relative to PC+1, so 8'hFF branches to itself.
   assign br_target = pc_inc + {{12{instr[7]}}, instr[7:0]};
   assign taken     = (state == S_EXEC) &&
                      ((opcode == OP_BR) || ((opcode == OP_BZ) && flag_z));

   // Outputs decode straight from state, so an asynchronous reset clears
   // them (including imem_req mid-fetch) without waiting for a clock edge.
   assign imem_req    = (state == S_FETCH);
   assign imem_addr   = imem_req ? pc : 20'd0;
   assign instr_valid = (state == S_EXEC) && (opcode != OP_BR) &&
                        (opcode != OP_BZ) && (opcode != OP_HALT);
   assign busy        = (state == S_FETCH) || (state == S_EXEC);
   assign halted      = (state == S_HALT);
   assign err         = (state == S_ERR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         pc      <= RESET_PC;
         instr   <= 16'd0;
         tmo_cnt <= 8'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) state <= S_FETCH;
            end
            S_FETCH: begin
               if (imem_ack) begin
                  instr   <= imem_data;
                  tmo_cnt <= 8'd0;
                  state   <= S_EXEC;
               end else if (tmo_cnt + 8'd1 == TMO_LIMIT) begin
                  tmo_cnt <= 8'd0;
                  state   <= S_ERR;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            S_EXEC: begin
               if (opcode == OP_HALT) begin
                  state <= S_HALT;
               end else begin
                  pc    <= taken ? br_target : pc_inc;
                  state <= S_FETCH;
               end
            end
            S_HALT: begin
               if (start) begin
                  pc    <= RESET_PC;
                  state <= S_FETCH;
               end
            end
            S_ERR: begin
               state <= S_ERR;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         taken_cnt <= 16'd0;
      end else if ((state == S_HALT) && start) begin
         taken_cnt <= 16'd0;
      end else if (taken && (taken_cnt != 16'hFFFF)) begin
         taken_cnt <= taken_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle program-counter controller for the 20-bit datapath.
- Fetches 16-bit instructions over a req/ack handshake.
- Hands non-control instructions to the datapath.
- Resolves branches by sign-extending the 8-bit instruction offset to 20 bits and adding it to PC+1.
- Sits between instruction memory and the execute datapath, and owns the PC register.

Parameters:
RESET_PC, 20'h00000, PC value loaded at reset and on restart from HALT.
TIMEOUT, 15, max FETCH cycles without imem_ack before entering ERR (range 1..255).

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  level-sampled start request; acted on only in IDLE or HALT
imem_req  output  1  fetch request, held high for the whole FETCH state
imem_addr  output  20  fetch address, equals pc while imem_req=1, else 0
imem_ack  input  1  memory response; imem_data valid in the same cycle
imem_data  input  16  instruction: [15:12] opcode, [11:8] unused, [7:0] signed offset
flag_z  input  1  zero flag from datapath, sampled in EXEC
pc  output  20  current PC register
instr  output  16  last fetched instruction register
instr_valid  output  1  one-cycle pulse: instr is a datapath op to execute
busy  output  1  high in FETCH and EXEC
halted  output  1  high in HALT
err  output  1  high in ERR

Behaviour:
- Reset (async, rst_n=0) forces the following, immediately and independent of clk:
  - state=IDLE, pc=RESET_PC, instr=0, timeout counter=0.
  - All 1-bit outputs 0, imem_addr=0.
  - Reset mid-FETCH drops imem_req immediately.
- States and transitions:
  - IDLE: start=1 -> FETCH.
  - FETCH: imem_req=1, imem_addr=pc.
    - imem_ack=1: latch instr<=imem_data, clear counter -> EXEC (ack may arrive in the first FETCH cycle; min fetch latency 1 cycle).
    - No ack: counter+1. When counter reaches TIMEOUT -> ERR.
    - ack in the same cycle the counter would reach TIMEOUT: ack wins.
  - EXEC: exactly one cycle; decode instr[15:12]:
    - 4'hA BR: pc <= pc + 1 + sext(instr[7:0]).
    - 4'hB BZ: if flag_z=1, same as BR; else pc <= pc+1.
    - 4'hF HALT: pc unchanged -> HALT.
    - Any other opcode: instr_valid=1 this cycle, pc <= pc+1.
    - All opcodes other than HALT -> FETCH.
  - HALT: halted=1. start=1 -> pc <= RESET_PC, -> FETCH.
  - ERR: err=1, terminal; only rst_n exits.
- Arithmetic:
  - sext = {12{off[7]}, off[7:0]}.
  - All PC adds are modulo 2^20 (wrap; no overflow flag).
  - Offset 8'hFF targets the branch itself; 8'h80 targets pc-127.
- start is ignored in FETCH, EXEC and ERR.
- Throughput: 2 cycles per instruction with zero-wait memory.

Optional Feature:
BRANCH_STATS_EN.
- Defined: adds output taken_cnt [15:0], which counts taken BR/BZ in EXEC.
  - Saturates at 16'hFFFF.
  - Cleared by rst_n and by restart from HALT.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset with RESET_PC=20'h00010, start=1, memory returns 16'h1234 with zero wait -> imem_addr=0x00010; instr_valid pulses one cycle later with instr=16'h1234; next fetch at 0x00011.
2. pc=0x00020, instr=16'hA0FE (BR, -2) -> next imem_addr=0x0001F. Then pc=0xFFFFF, instr=16'hA001 -> next address 0x00001 (wrap).
3. BZ 16'hB005 at pc=0x00100:
   - flag_z=1 -> next address 0x00106.
   - Repeat with flag_z=0 -> next address 0x00101.
   - instr_valid stays 0 in both cases.
4. Hold imem_ack=0 with TIMEOUT=3 -> err=1 after 3 FETCH cycles, imem_req=0, start has no effect. Ack on the 3rd cycle instead -> normal EXEC, err=0.
5. Fetch 16'hF000 -> halted=1, pc unchanged. start=1 -> fetch from RESET_PC. Pull rst_n low mid-FETCH -> imem_req=0 with no clock edge.
6. BRANCH_STATS_EN defined: run 3 taken and 1 not-taken branch -> taken_cnt=3. Build without the macro -> port absent and cases 1-5 still pass.
